alu_rr_scheduler: RTL and testbench
===================================

Name: alu_rr_scheduler

Overview:
- Shares one 8-bit ALU among four requesters: add/sub, bitwise logic, logical and arithmetic shifts.
- A round-robin arbiter grants one request at a time. The block registers the operands, computes in a dedicated execute cycle and holds the result under a valid/ready response handshake.
- Sits between client request ports and the single shared arithmetic resource in the datapath.

Parameters:
- WIDTH, 8, operand/result width in bits. Must be a power of 2, ≥4.
- SHW, $clog2(WIDTH), shift-amount width; only b[SHW-1:0] is used for shifts.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  4  per-requester request valid.
- req_ready  out  4  per-requester grant/accept, one-hot or zero; combinational.
- req_op  in  12  3-bit opcode per requester; requester i uses [3i+2:3i].
- req_a  in  4*WIDTH  operand A per requester, slice i.
- req_b  in  4*WIDTH  operand B per requester, slice i.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  2  index of the requester that owns the result.
- rsp_data  out  WIDTH  result.
- rsp_ovf  out  1  signed overflow for ADD/SUB; 0 for all other ops.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE, rr_ptr=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_ovf=0.
  - Operand registers cleared; req_ready=0 while rst is high.
- Opcodes:
  - 0 ADD: a+b, wrap mod 2^WIDTH.
  - 1 SUB: a-b, wrap mod 2^WIDTH.
  - 2 AND, 3 OR, 4 XOR.
  - 5 SLL: a<<b[SHW-1:0].
  - 6 SRL: logical right shift, zero fill.
  - 7 SRA: a treated as signed, sign fill.
- rsp_ovf:
  - ADD: operands share a sign and the result sign differs.
  - SUB: operand signs differ and the result sign differs from a.
- State IDLE:
  - Arbitration is purely combinational on req_valid and rr_ptr. Search order is rr_ptr, rr_ptr+1, ... mod 4; the first valid index g wins.
  - req_ready[g]=1; all other req_ready bits 0. No valid → req_ready=0.
  - Handshake: the transfer occurs at an edge where req_valid[g]=1 and req_ready[g]=1.
  - On transfer: latch op/a/b/g, set rr_ptr=g+1 mod 4, go to EXEC.
- State EXEC (1 cycle):
  - Compute result; register rsp_data, rsp_ovf, rsp_id=g; set rsp_valid=1; go to RESP.
  - req_ready=0.
- State RESP:
  - rsp_valid=1 held. rsp_data/rsp_id/rsp_ovf are stable until accepted.
  - req_ready=0.
  - rsp_ready=1 at edge → rsp_valid=0, go to IDLE. Next grant possible in the following cycle.
- Latency and throughput:
  - Request accepted at edge N → rsp_valid=1 after edge N+1.
  - With rsp_ready tied high, minimum issue interval is 3 cycles.
- Fairness:
  - A requester that just won has lowest priority next round.
  - Four continuously valid requesters are served 0,1,2,3,0,...
- Boundaries:
  - Requester deasserts req_valid before its grant: no transfer, no state change. Arbitration re-evaluates every IDLE cycle.
  - req_valid/operands of non-granted requesters are ignored. Operand changes after the transfer do not affect the result.
  - rsp_ready high while rsp_valid=0: no effect.
  - Reset during EXEC or RESP: in-flight operation is discarded with no response, and rr_ptr returns to 0.
  - Shift amount ≥ WIDTH cannot occur, since only SHW bits are used.

Test Plan:
- Reset then requester 0 ADD a=2, b=10, rsp_ready=1 → req_ready=4'b0001 in the request cycle; rsp_valid 2 edges later; rsp_data=12, rsp_id=0, rsp_ovf=0.
- Requester 1 ADD a=2, b=0xFD (-3) → rsp_data=0xFF, ovf=0. Requester 1 ADD a=0x7F, b=1 → rsp_data=0x80, ovf=1. Requester 1 SUB a=0x80, b=1 → rsp_data=0x7F, ovf=1.
- Requester 2 shifts with b=2:
  - a=0x1F: SLL → 0x7C, SRL → 0x07, SRA → 0x07.
  - a=0xE1 (-31): SRL → 0x38, SRA → 0xF8.
  - AND 0xFF & 0x0F → 0x0F; XOR 0xFF ^ 0x0F → 0xF0.
- All four req_valid held high, each with distinct operands, rsp_ready=1 → rsp_id sequence 0,1,2,3,0. Each grant is exactly 3 cycles apart, and each requester's result is correct.
- rsp_ready held low 5 cycles during RESP with requester 3 pending → rsp_valid, rsp_data, rsp_id constant; req_ready stays 0; requester 3 granted only after the response is accepted.
- Assert rst for 1 cycle while in EXEC → next cycle rsp_valid=0, state IDLE, no stale response. The subsequent request from requester 1 (rr_ptr=0, only requester 1 valid) is granted and completes correctly.

Source files
------------

// File: rtl/alu_rr_scheduler.sv
// Four-requester round-robin front end for one shared 8-bit ALU.
// A granted operation is registered, executed for one cycle, then held under a valid/ready response.
module alu_rr_scheduler #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           req_valid,
  output logic [3:0]           req_ready,
  input  logic [11:0]          req_op,
  input  logic [4*WIDTH-1:0]   req_a,
  input  logic [4*WIDTH-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [1:0]           rsp_id,
  output logic [WIDTH-1:0]     rsp_data,
  output logic                 rsp_ovf
);

  localparam int OPW = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [1:0]       r_rr_ptr;
  logic [OPW-1:0]   r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_gnt_id;
  logic             r_rsp_valid;
  logic [1:0]       r_rsp_id;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_ovf;

  logic             w_found;
  logic [1:0]       w_grant_idx;
  logic             w_xfer;
  logic [WIDTH:0]   w_alu_out;

  // Returns {signed_overflow, result}; overflow is only meaningful for ADD/SUB.
  function automatic logic [WIDTH:0] alu_compute(
    input logic [OPW-1:0]   op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] res;
    logic             ovf;
    logic [SHW-1:0]   sh;
    sh  = b[SHW-1:0];
    res = '0;
    ovf = 1'b0;
    case (op)
      3'd0: begin
        res = a + b;
        ovf = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      3'd1: begin
        res = a - b;
        ovf = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      3'd2:    res = a & b;
      3'd3:    res = a | b;
      3'd4:    res = a ^ b;
      3'd5:    res = a << sh;
      3'd6:    res = a >> sh;
      3'd7:    res = $signed(a) >>> sh;
      default: res = '0;
    endcase
    return {ovf, res};
  endfunction

  // Rotating priority search starting at r_rr_ptr; first valid index wins.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (!w_found && req_valid[r_rr_ptr + k[1:0]]) begin
        w_found     = 1'b1;
        w_grant_idx = r_rr_ptr + k[1:0];
      end else begin
        w_found     = w_found;
        w_grant_idx = w_grant_idx;
      end
    end
  end

  assign w_xfer    = (r_state == S_IDLE) && !rst && w_found;
  assign w_alu_out = alu_compute(r_op, r_a, r_b);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  w_next_state = w_xfer ? S_EXEC : S_IDLE;
      S_EXEC:  w_next_state = S_RESP;
      S_RESP:  w_next_state = rsp_ready ? S_IDLE : S_RESP;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Grant output: only offered while idle and out of reset.
  always_comb begin
    req_ready = 4'b0000;
    case (r_state)
      S_IDLE: begin
        if (!rst && w_found) begin
          req_ready = 4'b0001 << w_grant_idx;
        end else begin
          req_ready = 4'b0000;
        end
      end
      default: req_ready = 4'b0000;
    endcase
  end

  // Operand capture, pointer rotation and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= 2'd0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_gnt_id    <= 2'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 2'd0;
      r_rsp_data  <= '0;
      r_rsp_ovf   <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_op     <= req_op[w_grant_idx*OPW +: OPW];
        r_a      <= req_a[w_grant_idx*WIDTH +: WIDTH];
        r_b      <= req_b[w_grant_idx*WIDTH +: WIDTH];
        r_gnt_id <= w_grant_idx;
        r_rr_ptr <= w_grant_idx + 2'd1;
      end
      if (r_state == S_EXEC) begin
        r_rsp_data  <= w_alu_out[WIDTH-1:0];
        r_rsp_ovf   <= w_alu_out[WIDTH];
        r_rsp_id    <= r_gnt_id;
        r_rsp_valid <= 1'b1;
      end else if (r_state == S_RESP && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_ovf   = r_rsp_ovf;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed self-checking bench for alu_rr_scheduler with hand-computed expectations.
module tb_alu_rr_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [11:0] req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        rsp_ovf;

  int checks;
  int errors;

  alu_rr_scheduler #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ovf   (rsp_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    step();
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_data !== 8'h00 || rsp_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp: got v=%b id=%0d d=%h o=%b want 0/0/00/0", rsp_valid, rsp_id, rsp_data, rsp_ovf);
    end
    step();
    rst       = 1'b0;
    req_valid = 4'b0000;
  endtask

  // Single-requester transaction; entered one step after an edge with the DUT idle.
  task automatic do_op(input int id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_d, input logic exp_o, input string name);
    req_valid          = 4'b0000;
    req_valid[id]      = 1'b1;
    req_op[id*3 +: 3]  = op;
    req_a[id*8 +: 8]   = a;
    req_b[id*8 +: 8]   = b;
    rsp_ready          = 1'b1;
    #1;
    checks++;
    if (req_ready !== (4'b0001 << id)) begin
      errors++; $display("FAIL %s grant: got %b want %b", name, req_ready, 4'b0001 << id);
    end
    step();
    req_valid        = 4'b0000;
    req_a[id*8 +: 8] = ~a;
    req_b[id*8 +: 8] = ~b;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
      errors++; $display("FAIL %s exec: got v=%b rdy=%b want 0/0000", name, rsp_valid, req_ready);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== exp_d || rsp_id !== id[1:0] || rsp_ovf !== exp_o) begin
      errors++;
      $display("FAIL %s rsp: got v=%b d=%h id=%0d o=%b want 1/%h/%0d/%b",
               name, rsp_valid, rsp_data, rsp_id, rsp_ovf, exp_d, id, exp_o);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL %s accept: got v=%b want 0", name, rsp_valid);
    end
  endtask

  task automatic test_alu_ops();
    do_op(0, 3'd0, 8'h02, 8'h0A, 8'h0C, 1'b0, "add_basic");
    do_op(1, 3'd0, 8'h02, 8'hFD, 8'hFF, 1'b0, "add_neg");
    do_op(1, 3'd0, 8'h7F, 8'h01, 8'h80, 1'b1, "add_ovf");
    do_op(1, 3'd1, 8'h80, 8'h01, 8'h7F, 1'b1, "sub_ovf");
    do_op(2, 3'd5, 8'h1F, 8'h02, 8'h7C, 1'b0, "sll_pos");
    do_op(2, 3'd6, 8'h1F, 8'h02, 8'h07, 1'b0, "srl_pos");
    do_op(2, 3'd7, 8'h1F, 8'h02, 8'h07, 1'b0, "sra_pos");
    do_op(2, 3'd6, 8'hE1, 8'h02, 8'h38, 1'b0, "srl_neg");
    do_op(2, 3'd7, 8'hE1, 8'h02, 8'hF8, 1'b0, "sra_neg");
    do_op(2, 3'd2, 8'hFF, 8'h0F, 8'h0F, 1'b0, "and");
    do_op(2, 3'd4, 8'hFF, 8'h0F, 8'hF0, 1'b0, "xor");
    do_op(3, 3'd3, 8'hA0, 8'h05, 8'hA5, 1'b0, "or");
    do_op(3, 3'd5, 8'h03, 8'h0B, 8'h18, 1'b0, "sll_shw_bits");
    do_op(0, 3'd1, 8'h05, 8'h07, 8'hFE, 1'b0, "sub_noovf");
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_rr [4];
    int         id_exp;
    exp_rr[0] = 8'h11; exp_rr[1] = 8'h1D; exp_rr[2] = 8'h35; exp_rr[3] = 8'h4F;
    test_reset();
    req_op    = {3'd4, 3'd3, 3'd1, 3'd0};
    req_a     = {8'h40, 8'h30, 8'h20, 8'h10};
    req_b     = {8'h0F, 8'h05, 8'h03, 8'h01};
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    #1;
    for (int c = 0; c < 15; c++) begin
      id_exp = (c / 3) % 4;
      checks++;
      if (c % 3 == 0) begin
        if (req_ready !== (4'b0001 << id_exp)) begin
          errors++; $display("FAIL rr_grant c=%0d: got %b want %b", c, req_ready, 4'b0001 << id_exp);
        end
      end else begin
        if (req_ready !== 4'b0000) begin
          errors++; $display("FAIL rr_busy c=%0d: got %b want 0000", c, req_ready);
        end
      end
      if (c % 3 == 2) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== id_exp[1:0] || rsp_data !== exp_rr[id_exp]) begin
          errors++;
          $display("FAIL rr_rsp c=%0d: got v=%b id=%0d d=%h want 1/%0d/%h",
                   c, rsp_valid, rsp_id, rsp_data, id_exp, exp_rr[id_exp]);
        end
      end
      step();
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_backpressure();
    test_reset();
    req_op[2:0]   = 3'd2; req_a[7:0]   = 8'hF0; req_b[7:0]   = 8'h3C;
    req_op[11:9]  = 3'd5; req_a[31:24] = 8'h03; req_b[31:24] = 8'h0B;
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL bp_grant0: got %b want 0001", req_ready);
    end
    step();
    req_valid = 4'b1000;
    step();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'h30 || rsp_id !== 2'd0 || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold c=%0d: got v=%b d=%h id=%0d rdy=%b want 1/30/0/0000",
                 c, rsp_valid, rsp_data, rsp_id, req_ready);
      end
      step();
    end
    rsp_ready = 1'b1;
    step();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b1000) begin
      errors++; $display("FAIL bp_release: got v=%b rdy=%b want 0/1000", rsp_valid, req_ready);
    end
    step();
    req_valid = 4'b0000;
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h18 || rsp_id !== 2'd3 || rsp_ovf !== 1'b0) begin
      errors++;
      $display("FAIL bp_rsp3: got v=%b d=%h id=%0d o=%b want 1/18/3/0", rsp_valid, rsp_data, rsp_id, rsp_ovf);
    end
    step();
  endtask

  task automatic test_reset_in_exec();
    test_reset();
    rsp_ready = 1'b1;
    req_op[8:6] = 3'd0; req_a[23:16] = 8'h11; req_b[23:16] = 8'h22;
    req_valid = 4'b0100;
    step();
    req_valid = 4'b0000;
    rst       = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
      errors++; $display("FAIL rex_after_rst: got v=%b rdy=%b want 0/0000", rsp_valid, req_ready);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rex_no_stale: got v=%b want 0", rsp_valid);
    end
    req_op[5:3]  = 3'd1; req_a[15:8]  = 8'h09; req_b[15:8]  = 8'h04;
    req_op[11:9] = 3'd0; req_a[31:24] = 8'h01; req_b[31:24] = 8'h01;
    req_valid = 4'b1010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL rex_ptr_zero: got %b want 0010", req_ready);
    end
    step();
    req_valid = 4'b0000;
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h05 || rsp_id !== 2'd1 || rsp_ovf !== 1'b0) begin
      errors++;
      $display("FAIL rex_rsp: got v=%b d=%h id=%0d o=%b want 1/05/1/0", rsp_valid, rsp_data, rsp_id, rsp_ovf);
    end
    step();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    req_valid = 4'b0000;
    req_op    = 12'h000;
    req_a     = 32'h0;
    req_b     = 32'h0;
    rsp_ready = 1'b0;
    step();
    test_reset();
    test_alu_ops();
    test_round_robin();
    test_backpressure();
    test_reset_in_exec();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
